mipi_csi_tx_byte_framer: RTL and testbench
==========================================

// Module: mipi_csi_tx_byte_framer
// PURPOSE
//   Transmit-side HS burst framer for one D-PHY lane on the CSI-2 TX path; mirror of the RX byte aligner.
//   - Takes a packet byte stream from the lane distributor.
//   - Frames it as: SYNC leader (8'hB8) -> payload shifted behind the leader -> trailer -> idle gap.
//   - Drives the PHY request/ready handshake.
//   - Byte order on the wire is LSB-first: byte 0 occupies bits [7:0] and is transmitted first.
// PARAMETERS
//   MIPI_GEAR      16  lane word width in bits; legal values 8 or 16 (NB = MIPI_GEAR/8 bytes per word)
//   TRAILER_WORDS  2   full trailer words appended after the payload (>=1)
//   GAP_CYCLES     4   minimum idle cycles between bursts, HS-exit time (>=1)
// PORTS
//   clk_i          in   1          byte clock
//   reset_n_i      in   1          reset
//   in_valid_i     in   1          payload word valid
//   in_data_i      in   MIPI_GEAR  payload word, byte 0 in [7:0]
//   in_last_i      in   1          final word of packet
//   in_last_nb_i   in   2          valid bytes in final word (1..NB); ignored when !in_last_i
//   in_ready_o     out  1          payload word accepted this cycle
//   hs_request_o   out  1          HS request to PHY (TxRequestHS)
//   hs_ready_i     in   1          PHY accepts the current hs_word_o (TxReadyHS)
//   hs_word_o      out  MIPI_GEAR  word to serialise
//   hs_valid_o     out  1          hs_word_o valid
//   underrun_o     out  1          one-cycle pulse: in_valid_i dropped mid-packet
//   busy_o         out  1          state != IDLE
// BEHAVIOUR
// - Reset is asynchronous, active-low (reset_n_i); clock is clk_i.
//   - All outputs, state, carry byte and counters reset to 0 / IDLE.
//   - Reset mid-burst aborts immediately: no trailer is emitted.
// - FSM states: IDLE -> REQ -> LEAD -> DATA -> TRAIL -> GAP -> IDLE.
// - IDLE: in_ready_o=0. When in_valid_i=1, go to REQ next cycle.
// - REQ: hs_request_o=1 (held high from REQ through TRAIL). Wait for hs_ready_i=1, then go to LEAD.
// - LEAD: consumes the first payload word.
//   - Gear 8: emit 8'hB8 alone; no payload is consumed in this state.
//   - Gear 16: emit {in_data_i[7:0], 8'hB8}; in_ready_o=hs_ready_i; carry <= in_data_i[15:8].
//   - If that word is last with nb=1: go to TRAIL and record last byte = in_data_i[7:0].
// - DATA: in_ready_o = hs_ready_i & in_valid_i.
//   - Gear 16: emit {in_data_i[7:0], carry}; carry <= [15:8].
//   - Last word, nb=1: the word completes the burst; go to TRAIL.
//   - Last word, nb=2: the carried byte is still pending; emit {T, carry} as the first TRAIL word.
//   - Gear 8: pass the word through unchanged.
// - Trailer byte T: every bit equals ~(MSB of the last payload byte transmitted), i.e. 8'hFF or 8'h00.
//   - Latched when the last byte is accepted.
//   - TRAIL emits TRAILER_WORDS words of {NB{T}}, not counting a partial {T, carry} word.
// - Output timing and handshake:
//   - hs_word_o and hs_valid_o are registered, updating one cycle after acceptance.
//   - hs_valid_o=1 continuously from LEAD through TRAIL. The RX resyncs on any valid gap.
//   - hs_ready_i=0 holds hs_word_o, the state and in_ready_o=0.
// - Underrun: in DATA with in_valid_i=0 and hs_ready_i=1:
//   - pulse underrun_o;
//   - latch T from the last byte sent;
//   - go to TRAIL (gear 16 with carry pending: emit {T, carry} first).
//   - Remaining input words of that packet are not consumed.
// - GAP: hs_request_o=0, hs_valid_o=0; count GAP_CYCLES, then IDLE.
//   - in_valid_i asserted during GAP is ignored until IDLE.
// - Counters: trailer counter is $clog2(TRAILER_WORDS+1) bits, gap counter $clog2(GAP_CYCLES+1) bits; both saturate and clear on entry.
// STRUCTURE
// - Shared package mipi_csi_pkg holds:
//   - CSI_SYNC_BYTE = 8'hB8 (also used by the RX aligner);
//   - typedef enum tx_framer_state_e {IDLE, REQ, LEAD, DATA, TRAIL, GAP}.
// - One sub-module is natural: mipi_csi_tx_trailer_gen (latches T, counts trailer words).
//   Everything else is one FSM plus the carry register.
// TESTING (MIPI_GEAR=16, TRAILER_WORDS=2, GAP_CYCLES=4, hs_ready_i=1 unless noted)
// 1. Bytes 11,22,33,44 (words 16'h2211, 16'h4433 nb=2) -> hs_word_o 11B8, 3322, FF44, FFFF, FFFF; then 4 idle cycles.
// 2. Bytes 11,22,33 (16'h2211, 16'h0033 nb=1) -> 11B8, 3322, FFFF, FFFF.
// 3. Last byte 8'h80 (single word 16'h0080 nb=1) -> 80B8, 0000, 0000.
// 4. hs_ready_i low 3 cycles mid-DATA -> hs_word_o stable, in_ready_o=0, no byte lost or duplicated.
// 5. in_valid_i drops after first word 16'h2211 -> 11B8, underrun_o pulse, FF22, FFFF, FFFF.
// 6. Reset asserted during TRAIL -> next-edge outputs 0, state IDLE; a new packet then starts with REQ.
// 7. Back-to-back packets: next hs_request_o no earlier than 4 cycles after previous hs_valid_o falls.

Source files
------------

// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: CSI-2 constants and TX framer state encoding shared by TX framer and RX aligner
package mipi_csi_pkg;

    localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {IDLE, REQ, LEAD, DATA, TRAIL, GAP} tx_framer_state_e;

    // Trailer bytes invert the final payload MSB so the RX sees a guaranteed transition
    function automatic logic [7:0] trailer_byte(input logic [7:0] last_byte);
        return {8{~last_byte[7]}};
    endfunction

endpackage

// File: rtl/mipi_csi_tx_trailer_gen.sv
// mipi_csi_tx_trailer_gen: latches the trailer byte and counts emitted full trailer words
module mipi_csi_tx_trailer_gen
    import mipi_csi_pkg::*;
#(
    parameter int TRAILER_WORDS = 2
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start,
    input  logic [7:0] last_byte,
    input  logic       step,
    output logic [7:0] t_byte,
    output logic       done
);

    localparam int CW = $clog2(TRAILER_WORDS + 1);

    logic [CW-1:0] cnt;

    assign done = cnt == CW'(TRAILER_WORDS);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            t_byte <= '0;
            cnt    <= '0;
        end else if (start) begin
            t_byte <= trailer_byte(last_byte);
            cnt    <= '0;
        end else if (step && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mipi_csi_tx_byte_framer.sv
// mipi_csi_tx_byte_framer: frames a lane byte stream into an HS burst (sync leader, payload, trailer, gap)
module mipi_csi_tx_byte_framer
    import mipi_csi_pkg::*;
#(
    parameter int MIPI_GEAR     = 16,
    parameter int TRAILER_WORDS = 2,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 in_valid_i,
    input  logic [MIPI_GEAR-1:0] in_data_i,
    input  logic                 in_last_i,
    input  logic [1:0]           in_last_nb_i,
    output logic                 in_ready_o,
    output logic                 hs_request_o,
    input  logic                 hs_ready_i,
    output logic [MIPI_GEAR-1:0] hs_word_o,
    output logic                 hs_valid_o,
    output logic                 underrun_o,
    output logic                 busy_o
);

    localparam int NB  = MIPI_GEAR / 8;
    localparam bit G16 = MIPI_GEAR == 16;
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    tx_framer_state_e state;
    logic [7:0]       carry;
    logic             pending;
    logic [GW-1:0]    gap_cnt;
    logic             split, underrun_now, t_start, t_step, t_done;
    logic [7:0]       t_src, t_byte;

    assign busy_o       = state != IDLE;
    assign in_ready_o   = hs_ready_i && in_valid_i && (state == DATA || (G16 && state == LEAD));
    assign underrun_now = state == DATA && hs_ready_i && !in_valid_i;
    // A two-byte final word leaves its upper byte in carry, to be sent with the first trailer byte
    assign split        = G16 && in_last_i && in_last_nb_i != 2'd1;
    assign t_start      = (in_ready_o && in_last_i) || underrun_now;
    assign t_step       = state == TRAIL && hs_ready_i && !pending;
    assign t_src        = underrun_now ? (G16 ? carry : hs_word_o[7:0])
                        : split ? in_data_i[MIPI_GEAR-1 -: 8] : in_data_i[7:0];

    mipi_csi_tx_trailer_gen #(.TRAILER_WORDS(TRAILER_WORDS)) u_trailer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start     (t_start),
        .last_byte (t_src),
        .step      (t_step),
        .t_byte    (t_byte),
        .done      (t_done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            carry        <= '0;
            pending      <= 1'b0;
            gap_cnt      <= '0;
            hs_word_o    <= '0;
            hs_valid_o   <= 1'b0;
            hs_request_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            case (state)
                IDLE: if (in_valid_i) begin
                    state        <= REQ;
                    hs_request_o <= 1'b1;
                end
                REQ: if (hs_ready_i) state <= LEAD;
                LEAD: if (hs_ready_i && (in_valid_i || !G16)) begin
                    hs_word_o  <= MIPI_GEAR'({in_data_i[7:0], CSI_SYNC_BYTE});
                    hs_valid_o <= 1'b1;
                    carry      <= in_data_i[MIPI_GEAR-1 -: 8];
                    pending    <= split;
                    state      <= (G16 && in_last_i) ? TRAIL : DATA;
                end
                DATA: if (hs_ready_i) begin
                    if (in_valid_i) begin
                        hs_word_o <= G16 ? MIPI_GEAR'({in_data_i[7:0], carry}) : in_data_i;
                        carry     <= in_data_i[MIPI_GEAR-1 -: 8];
                        pending   <= split;
                        state     <= in_last_i ? TRAIL : DATA;
                    end else begin
                        underrun_o <= 1'b1;
                        pending    <= G16;
                        state      <= TRAIL;
                    end
                end
                TRAIL: if (hs_ready_i) begin
                    if (pending) begin
                        hs_word_o <= MIPI_GEAR'({t_byte, carry});
                        pending   <= 1'b0;
                    end else if (!t_done) begin
                        hs_word_o <= {NB{t_byte}};
                    end else begin
                        state        <= GAP;
                        hs_valid_o   <= 1'b0;
                        hs_request_o <= 1'b0;
                        gap_cnt      <= '0;
                    end
                end
                GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                     else gap_cnt <= gap_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx_byte_framer.sv
// tb_mipi_csi_tx_byte_framer: directed cycle-by-cycle checks of the gear-16 HS burst framer
module tb_mipi_csi_tx_byte_framer;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, hs_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic [1:0]  in_nb = '0;
    logic        in_ready, hs_request, hs_valid, underrun, busy;
    logic [15:0] hs_word;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mipi_csi_tx_byte_framer #(.MIPI_GEAR(16), .TRAILER_WORDS(2), .GAP_CYCLES(4)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_last_nb_i (in_nb),
        .in_ready_o   (in_ready),
        .hs_request_o (hs_request),
        .hs_ready_i   (hs_ready),
        .hs_word_o    (hs_word),
        .hs_valid_o   (hs_valid),
        .underrun_o   (underrun),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // f = {hs_valid, hs_request, in_ready, busy, underrun}; word compared only while valid
    task automatic cyc(input string tag, input logic [15:0] w, input logic [4:0] f);
        @(negedge clk);
        if (f[4]) chk({tag, ".word"}, hs_word, w);
        chk({tag, ".valid"}, 16'(hs_valid), 16'(f[4]));
        chk({tag, ".req"}, 16'(hs_request), 16'(f[3]));
        chk({tag, ".ready"}, 16'(in_ready), 16'(f[2]));
        chk({tag, ".busy"}, 16'(busy), 16'(f[1]));
        chk({tag, ".underrun"}, 16'(underrun), 16'(f[0]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        chk("rst.word", hs_word, 16'h0);
        chk("rst.flags", 16'({hs_valid, hs_request, in_ready, busy, underrun}), 16'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: four bytes, final word nb=2 -> partial {T, carry} then two full trailer words
        in_valid = 1'b1; in_data = 16'h2211; in_last = 1'b0;
        cyc("t1.idle", 16'h0, 5'b00000);
        cyc("t1.req", 16'h0, 5'b01010);
        cyc("t1.lead", 16'h0, 5'b01110);
        in_data = 16'h4433; in_last = 1'b1; in_nb = 2'd2;
        cyc("t1.w0", 16'h11B8, 5'b11110);
        in_valid = 1'b0; in_last = 1'b0;
        cyc("t1.w1", 16'h3322, 5'b11010);
        cyc("t1.w2", 16'hFF44, 5'b11010);
        cyc("t1.w3", 16'hFFFF, 5'b11010);
        cyc("t1.w4", 16'hFFFF, 5'b11010);
        repeat (4) cyc("t1.gap", 16'h0, 5'b00010);

        // 2: three bytes, final word nb=1
        in_valid = 1'b1; in_data = 16'h2211;
        cyc("t2.idle", 16'h0, 5'b00000);
        cyc("t2.req", 16'h0, 5'b01010);
        cyc("t2.lead", 16'h0, 5'b01110);
        in_data = 16'h0033; in_last = 1'b1; in_nb = 2'd1;
        cyc("t2.w0", 16'h11B8, 5'b11110);
        // next packet (3) already offered during trailer and gap (7)
        in_data = 16'h0080; in_last = 1'b1; in_nb = 2'd1;
        cyc("t2.w1", 16'h3322, 5'b11010);
        cyc("t2.w2", 16'hFFFF, 5'b11010);
        cyc("t2.w3", 16'hFFFF, 5'b11010);
        repeat (4) cyc("t7.gap", 16'h0, 5'b00010);
        cyc("t7.idle", 16'h0, 5'b00000);

        // 3: single word with last byte 80 -> trailer 00
        cyc("t3.req", 16'h0, 5'b01010);
        cyc("t3.lead", 16'h0, 5'b01110);
        in_valid = 1'b0; in_last = 1'b0;
        cyc("t3.w0", 16'h80B8, 5'b11010);
        cyc("t3.w1", 16'h0000, 5'b11010);
        cyc("t3.w2", 16'h0000, 5'b11010);
        repeat (4) cyc("t3.gap", 16'h0, 5'b00010);

        // 4: PHY stalls three cycles mid-DATA
        in_valid = 1'b1; in_data = 16'h2211;
        cyc("t4.idle", 16'h0, 5'b00000);
        cyc("t4.req", 16'h0, 5'b01010);
        cyc("t4.lead", 16'h0, 5'b01110);
        in_data = 16'h4433;
        cyc("t4.w0", 16'h11B8, 5'b11110);
        in_data = 16'h6655; in_last = 1'b1; in_nb = 2'd2; hs_ready = 1'b0;
        repeat (3) cyc("t4.stall", 16'h3322, 5'b11010);
        hs_ready = 1'b1;
        cyc("t4.resume", 16'h3322, 5'b11110);
        in_valid = 1'b0; in_last = 1'b0;
        cyc("t4.w2", 16'h5544, 5'b11010);
        cyc("t4.w3", 16'hFF66, 5'b11010);
        cyc("t4.w4", 16'hFFFF, 5'b11010);
        cyc("t4.w5", 16'hFFFF, 5'b11010);
        repeat (4) cyc("t4.gap", 16'h0, 5'b00010);

        // 5: source drops after the first word
        in_valid = 1'b1; in_data = 16'h2211;
        cyc("t5.idle", 16'h0, 5'b00000);
        cyc("t5.req", 16'h0, 5'b01010);
        cyc("t5.lead", 16'h0, 5'b01110);
        in_valid = 1'b0;
        cyc("t5.drop", 16'h11B8, 5'b11010);
        cyc("t5.und", 16'h11B8, 5'b11011);
        cyc("t5.w1", 16'hFF22, 5'b11010);
        cyc("t5.w2", 16'hFFFF, 5'b11010);
        cyc("t5.w3", 16'hFFFF, 5'b11010);
        repeat (4) cyc("t5.gap", 16'h0, 5'b00010);

        // 6: reset during TRAIL aborts; next packet restarts from REQ
        in_valid = 1'b1; in_data = 16'h2211;
        cyc("t6.idle", 16'h0, 5'b00000);
        cyc("t6.req", 16'h0, 5'b01010);
        cyc("t6.lead", 16'h0, 5'b01110);
        in_data = 16'h4433; in_last = 1'b1; in_nb = 2'd2;
        cyc("t6.w0", 16'h11B8, 5'b11110);
        in_valid = 1'b0; in_last = 1'b0;
        cyc("t6.w1", 16'h3322, 5'b11010);
        reset_n = 1'b0;
        cyc("t6.rst", 16'h0, 5'b00000);
        chk("t6.rst.word", hs_word, 16'h0);
        reset_n = 1'b1; in_valid = 1'b1; in_data = 16'h2211;
        cyc("t6.idle2", 16'h0, 5'b00000);
        cyc("t6.req2", 16'h0, 5'b01010);
        cyc("t6.lead2", 16'h0, 5'b01110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
